// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - Shared NPC core constants: ALU operation codes, opcodes and decode enums
package npc_pkg;

  localparam int XLEN = 32;

  // ALU operation codes, shared with the ALU
  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_SUB   = 5'b00010;
  localparam logic [4:0] ALU_JALR  = 5'b00011;
  localparam logic [4:0] ALU_SLTU  = 5'b00100;
  localparam logic [4:0] ALU_XOR   = 5'b00101;
  localparam logic [4:0] ALU_OR    = 5'b00110;
  localparam logic [4:0] ALU_AND   = 5'b00111;
  localparam logic [4:0] ALU_SLL   = 5'b01000;
  localparam logic [4:0] ALU_SRA   = 5'b01001;
  localparam logic [4:0] ALU_SRL   = 5'b01010;
  localparam logic [4:0] ALU_SLT   = 5'b01100;
  localparam logic [4:0] ALU_BEQ   = 5'b01101;
  localparam logic [4:0] ALU_BGE   = 5'b01110;
  localparam logic [4:0] ALU_BGEU  = 5'b01111;
  localparam logic [4:0] ALU_BLT   = 5'b10000;
  localparam logic [4:0] ALU_BLTU  = 5'b10001;
  localparam logic [4:0] ALU_BNE   = 5'b10010;
  localparam logic [4:0] ALU_SLLI  = 5'b10011;
  localparam logic [4:0] ALU_SRAI  = 5'b10100;
  localparam logic [4:0] ALU_SRLI  = 5'b10101;
  localparam logic [4:0] ALU_CSRRS = 5'b10110;
  localparam logic [4:0] ALU_CSRRW = 5'b10111;

  // RV32I + Zicsr major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    SRC1_RS1,
    SRC1_PC,
    SRC1_ZERO
  } src1_sel_e;

endpackage

// File: rtl/idu_imm_gen.sv
// rtl/idu_imm_gen.sv - Combinational immediate generator, sign-extends the I/S/B/U/J immediate
//
// Ports:
//   inst_i  : instruction bits [31:7] (opcode field is not needed here)
//   fmt_i   : immediate format selected by the decoder
//   imm_o   : sign-extended 32-bit immediate
module idu_imm_gen
  import npc_pkg::*;
(
  input  logic [31:7]     inst_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U: imm_o = {inst_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/idu_decode.sv
// rtl/idu_decode.sv - Registered RV32I+Zicsr decode stage producing ALU control and operands
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready             : handshake from the IFU
//   in_inst, in_pc                : fetched instruction and its PC
//   rs1_data, rs2_data, csr_rdata : same-cycle regfile/CSR reads for in_inst
//   flush                         : kill the held instruction (and any one being accepted)
//   out_valid/out_ready           : handshake to the EXU
//   out_alu_ctrl, out_src1/2, out_csr : ALU control and operands
//   out_inst, out_pc, out_rd, out_rf_wen, out_illegal : pass-through and writeback info
module idu_decode
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [XLEN-1:0] out_csr,
  output logic [31:0]     out_inst,
  output logic [31:0]     out_pc,
  output logic [4:0]      out_rd,
  output logic            out_rf_wen,
  output logic            out_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign rd     = in_inst[11:7];

  logic [4:0]      alu_d;
  imm_fmt_e        fmt;
  src1_sel_e       src1_sel;
  logic            src2_rs2;
  logic            csr_op;
  logic            writes_rd;
  logic            illegal_d;
  logic            rf_wen_d;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] src1_d;
  logic [XLEN-1:0] src2_d;
  logic [XLEN-1:0] csr_d;

  idu_imm_gen u_imm_gen (
    .inst_i (in_inst[31:7]),
    .fmt_i  (fmt),
    .imm_o  (imm)
  );

  // Opcode/funct decode into ALU code and operand-routing controls
  always_comb begin
    alu_d     = ALU_ADD;
    fmt       = IMM_I;
    src1_sel  = SRC1_RS1;
    src2_rs2  = 1'b0;
    csr_op    = 1'b0;
    writes_rd = 1'b0;
    illegal_d = 1'b0;
    case (opcode)
      OPC_OP: begin
        src2_rs2  = 1'b1;
        writes_rd = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: alu_d = ALU_ADD;
          {7'b0100000, 3'b000}: alu_d = ALU_SUB;
          {7'b0000000, 3'b001}: alu_d = ALU_SLL;
          {7'b0000000, 3'b010}: alu_d = ALU_SLT;
          {7'b0000000, 3'b011}: alu_d = ALU_SLTU;
          {7'b0000000, 3'b100}: alu_d = ALU_XOR;
          {7'b0000000, 3'b101}: alu_d = ALU_SRL;
          {7'b0100000, 3'b101}: alu_d = ALU_SRA;
          {7'b0000000, 3'b110}: alu_d = ALU_OR;
          {7'b0000000, 3'b111}: alu_d = ALU_AND;
          default:              illegal_d = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        case (funct3)
          3'b000: alu_d = ALU_ADD;
          3'b010: alu_d = ALU_SLT;
          3'b011: alu_d = ALU_SLTU;
          3'b100: alu_d = ALU_XOR;
          3'b110: alu_d = ALU_OR;
          3'b111: alu_d = ALU_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) alu_d = ALU_SLLI;
            else                      illegal_d = 1'b1;
          end
          default: begin
            // funct3 101: funct7 distinguishes logical from arithmetic shift
            if      (funct7 == 7'b0000000) alu_d = ALU_SRLI;
            else if (funct7 == 7'b0100000) alu_d = ALU_SRAI;
            else                           illegal_d = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        writes_rd = 1'b1;
        illegal_d = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        fmt       = IMM_S;
        illegal_d = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        fmt      = IMM_B;
        src2_rs2 = 1'b1;
        case (funct3)
          3'b000:  alu_d = ALU_BEQ;
          3'b001:  alu_d = ALU_BNE;
          3'b100:  alu_d = ALU_BLT;
          3'b101:  alu_d = ALU_BGE;
          3'b110:  alu_d = ALU_BLTU;
          3'b111:  alu_d = ALU_BGEU;
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_LUI: begin
        fmt       = IMM_U;
        alu_d     = ALU_LUI;
        src1_sel  = SRC1_ZERO;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        fmt       = IMM_U;
        src1_sel  = SRC1_PC;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        fmt       = IMM_J;
        src1_sel  = SRC1_PC;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        alu_d     = ALU_JALR;
        writes_rd = 1'b1;
        illegal_d = (funct3 != 3'b000);
      end
      OPC_SYSTEM: begin
        csr_op    = 1'b1;
        writes_rd = 1'b1;
        case (funct3)
          3'b001:  alu_d = ALU_CSRRW;
          3'b010:  alu_d = ALU_CSRRS;
          default: illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase
    // An undecodable instruction travels as a harmless no-op so the EXU can trap on it
    if (illegal_d) begin
      alu_d     = ALU_ADD;
      writes_rd = 1'b0;
      csr_op    = 1'b0;
    end
  end

  // Operand selection is kept apart from the decode so the immediate path is acyclic
  always_comb begin
    src1_d = rs1_data;
    case (src1_sel)
      SRC1_PC:   src1_d = in_pc;
      SRC1_ZERO: src1_d = '0;
      default:   src1_d = rs1_data;
    endcase
    src2_d   = src2_rs2 ? rs2_data : imm;
    csr_d    = csr_op ? csr_rdata : '0;
    rf_wen_d = writes_rd && (rd != 5'd0);
  end

  logic out_valid_q, out_valid_d;
  logic accept;
  logic load;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A flush coinciding with an accept drops the incoming instruction
  assign load     = accept && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  logic [4:0]      alu_q;
  logic [XLEN-1:0] src1_q, src2_q, csr_q;
  logic [31:0]     inst_q, pc_q;
  logic [4:0]      rd_q;
  logic            rf_wen_q, illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      csr_q     <= '0;
      inst_q    <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      rf_wen_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load) begin
      alu_q     <= alu_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      csr_q     <= csr_d;
      inst_q    <= in_inst;
      pc_q      <= in_pc;
      rd_q      <= rd;
      rf_wen_q  <= rf_wen_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_alu_ctrl = alu_q;
  assign out_src1     = src1_q;
  assign out_src2     = src2_q;
  assign out_csr      = csr_q;
  assign out_inst     = inst_q;
  assign out_pc       = pc_q;
  assign out_rd       = rd_q;
  assign out_rf_wen   = rf_wen_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_idu_decode.sv
// tb/tb_idu_decode.sv - Self-checking bench for idu_decode: directed cases plus randomized stream
module tb_idu_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] csr_rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alu_ctrl;
  logic [31:0] out_src1;
  logic [31:0] out_src2;
  logic [31:0] out_csr;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rf_wen;
  logic        out_illegal;

  always #5 clk = ~clk;

  idu_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .csr_rdata    (csr_rdata),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_src1     (out_src1),
    .out_src2     (out_src2),
    .out_csr      (out_csr),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_rd       (out_rd),
    .out_rf_wen   (out_rf_wen),
    .out_illegal  (out_illegal)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Instruction classes of the reference table
  localparam int K_R = 0, K_I = 1, K_SH = 2, K_LD = 3, K_ST = 4, K_BR = 5;
  localparam int K_LUI = 6, K_AUIPC = 7, K_JAL = 8, K_JALR = 9, K_CSR = 10;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int         kind;
    logic [4:0] alu;
  } ent_t;

  // What an instruction should produce, independent of the operand values
  typedef struct {
    logic        ill;
    logic [4:0]  alu;
    int          s1;      // 0 = rs1, 1 = pc, 2 = zero
    logic        s2_rs2;
    logic [31:0] imm;
    logic        is_csr;
    logic        wen;
  } exp_t;

  typedef struct {
    logic [4:0]  alu;
    logic [31:0] src1, src2, csr, inst, pc;
    logic [4:0]  rd;
    logic        wen, ill;
  } out_t;

  ent_t tbl[$];

  task automatic add(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                     input int kind, input logic [4:0] alu);
    ent_t t;
    t.opc = opc; t.f3 = f3; t.f7 = f7; t.kind = kind; t.alu = alu;
    tbl.push_back(t);
  endtask

  task automatic build_table();
    add(7'h33, 3'd0, 7'h00, K_R, 5'd0);   add(7'h33, 3'd0, 7'h20, K_R, 5'd2);
    add(7'h33, 3'd1, 7'h00, K_R, 5'd8);   add(7'h33, 3'd2, 7'h00, K_R, 5'd12);
    add(7'h33, 3'd3, 7'h00, K_R, 5'd4);   add(7'h33, 3'd4, 7'h00, K_R, 5'd5);
    add(7'h33, 3'd5, 7'h00, K_R, 5'd10);  add(7'h33, 3'd5, 7'h20, K_R, 5'd9);
    add(7'h33, 3'd6, 7'h00, K_R, 5'd6);   add(7'h33, 3'd7, 7'h00, K_R, 5'd7);
    add(7'h13, 3'd0, 7'h00, K_I, 5'd0);   add(7'h13, 3'd2, 7'h00, K_I, 5'd12);
    add(7'h13, 3'd3, 7'h00, K_I, 5'd4);   add(7'h13, 3'd4, 7'h00, K_I, 5'd5);
    add(7'h13, 3'd6, 7'h00, K_I, 5'd6);   add(7'h13, 3'd7, 7'h00, K_I, 5'd7);
    add(7'h13, 3'd1, 7'h00, K_SH, 5'd19); add(7'h13, 3'd5, 7'h00, K_SH, 5'd21);
    add(7'h13, 3'd5, 7'h20, K_SH, 5'd20);
    add(7'h03, 3'd0, 7'h00, K_LD, 5'd0);  add(7'h03, 3'd1, 7'h00, K_LD, 5'd0);
    add(7'h03, 3'd2, 7'h00, K_LD, 5'd0);  add(7'h03, 3'd4, 7'h00, K_LD, 5'd0);
    add(7'h03, 3'd5, 7'h00, K_LD, 5'd0);
    add(7'h23, 3'd0, 7'h00, K_ST, 5'd0);  add(7'h23, 3'd1, 7'h00, K_ST, 5'd0);
    add(7'h23, 3'd2, 7'h00, K_ST, 5'd0);
    add(7'h63, 3'd0, 7'h00, K_BR, 5'd13); add(7'h63, 3'd1, 7'h00, K_BR, 5'd18);
    add(7'h63, 3'd4, 7'h00, K_BR, 5'd16); add(7'h63, 3'd5, 7'h00, K_BR, 5'd14);
    add(7'h63, 3'd6, 7'h00, K_BR, 5'd17); add(7'h63, 3'd7, 7'h00, K_BR, 5'd15);
    add(7'h37, 3'd0, 7'h00, K_LUI, 5'd1); add(7'h17, 3'd0, 7'h00, K_AUIPC, 5'd0);
    add(7'h6F, 3'd0, 7'h00, K_JAL, 5'd0); add(7'h67, 3'd0, 7'h00, K_JALR, 5'd3);
    add(7'h73, 3'd1, 7'h00, K_CSR, 5'd23); add(7'h73, 3'd2, 7'h00, K_CSR, 5'd22);
  endtask

  function automatic logic legal_opc(input logic [6:0] o);
    return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
  endfunction

  // Build a random instruction by encoding chosen field values; the expectation
  // comes from those chosen values, not from decoding the word again.
  task automatic make_inst(output logic [31:0] inst, output exp_t e);
    logic [31:0] r, r2;
    logic [4:0]  rd, rs1f, rs2f;
    logic [6:0]  o;
    ent_t        t;
    int          k;
    r = $urandom;
    rd = r[4:0]; rs1f = r[9:5]; rs2f = r[14:10];
    e.ill = 1'b0; e.alu = 5'd0; e.s1 = 0; e.s2_rs2 = 1'b0;
    e.imm = 32'd0; e.is_csr = 1'b0; e.wen = 1'b0;
    inst = 32'd0;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) begin
      k = $urandom_range(0, 3);
      case (k)
        0: begin
          do begin r2 = $urandom; o = r2[6:0]; end while (legal_opc(o));
          inst = {r[31:7], o};
        end
        1: inst = {7'h01, r[24:12], r[11:7], 7'h33};
        2: inst = {r[31:15], 3'b010, r[11:7], 7'h63};
        default: inst = {r[31:15], 3'b000, r[11:7], 7'h73};
      endcase
      e.ill = 1'b1;
    end else begin
      t = tbl[$urandom_range(0, tbl.size() - 1)];
      e.alu = t.alu;
      case (t.kind)
        K_R: begin
          inst = {t.f7, rs2f, rs1f, t.f3, rd, t.opc};
          e.s2_rs2 = 1'b1; e.wen = 1'b1;
        end
        K_SH: begin
          inst = {t.f7, rs2f, rs1f, t.f3, rd, t.opc};
          e.imm = {20'd0, t.f7, rs2f}; e.wen = 1'b1;
        end
        K_ST: begin
          inst = {r[11:5], rs2f, rs1f, t.f3, r[4:0], t.opc};
          e.imm = {{20{r[11]}}, r[11:0]};
        end
        K_BR: begin
          inst = {r[31:25], rs2f, rs1f, t.f3, r[11:7], t.opc};
          e.s2_rs2 = 1'b1;
        end
        K_LUI, K_AUIPC: begin
          inst = {r[31:12], rd, t.opc};
          e.imm = {r[31:12], 12'd0};
          e.s1 = (t.kind == K_LUI) ? 2 : 1; e.wen = 1'b1;
        end
        K_JAL: begin
          inst = {r[20], r[10:1], r[11], r[19:12], rd, t.opc};
          e.imm = {{11{r[20]}}, r[20:1], 1'b0};
          e.s1 = 1; e.wen = 1'b1;
        end
        default: begin // K_I, K_LD, K_JALR, K_CSR
          inst = {r[11:0], rs1f, t.f3, rd, t.opc};
          e.imm = {{20{r[11]}}, r[11:0]};
          e.wen = 1'b1; e.is_csr = (t.kind == K_CSR);
        end
      endcase
      if (inst[11:7] == 5'd0) e.wen = 1'b0;
    end
  endtask

  function automatic out_t resolve(input exp_t e, input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    out_t o;
    o.inst = inst; o.pc = pc; o.rd = inst[11:7];
    o.alu  = e.ill ? 5'd0 : e.alu;
    o.wen  = e.ill ? 1'b0 : e.wen;
    o.ill  = e.ill;
    o.src1 = (e.s1 == 1) ? pc : (e.s1 == 2) ? 32'd0 : a;
    o.src2 = e.s2_rs2 ? b : e.imm;
    o.csr  = e.is_csr ? c : 32'd0;
    return o;
  endfunction

  task automatic check_out(input out_t m);
    check("alu_ctrl", {27'd0, out_alu_ctrl}, {27'd0, m.alu});
    check("inst", out_inst, m.inst);
    check("pc", out_pc, m.pc);
    check("rd", {27'd0, out_rd}, {27'd0, m.rd});
    check("rf_wen", {31'd0, out_rf_wen}, {31'd0, m.wen});
    check("illegal", {31'd0, out_illegal}, {31'd0, m.ill});
    if (!m.ill) begin
      check("src1", out_src1, m.src1);
      check("src2", out_src2, m.src2);
      check("csr", out_csr, m.csr);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic rdy);
    @(negedge clk);
    in_inst = i; in_pc = p; rs1_data = a; rs2_data = b; csr_rdata = c;
    in_valid = 1'b1; out_ready = rdy; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic        m_valid;
  out_t        m_out;
  exp_t        cur_e;
  logic [31:0] cur_inst;
  logic        exp_rdy;

  initial begin
    build_table();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    rs1_data = '0; rs2_data = '0; csr_rdata = '0; flush = 1'b0; out_ready = 1'b0;

    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_alu_ctrl", {27'd0, out_alu_ctrl}, 32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_src2", out_src2, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // addi x5,x0,-1
    push(32'hFFF00293, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_alu", {27'd0, out_alu_ctrl}, 32'd0);
    check("addi_src2", out_src2, 32'hFFFFFFFF);
    check("addi_rd", {27'd0, out_rd}, 32'd5);
    check("addi_wen", {31'd0, out_rf_wen}, 32'd1);

    // auipc x1,0x12345
    push(32'h12345097, 32'h80000000, 32'h0, 32'h0, 32'h0, 1'b1);
    check("auipc_src1", out_src1, 32'h80000000);
    check("auipc_src2", out_src2, 32'h12345000);
    check("auipc_alu", {27'd0, out_alu_ctrl}, 32'd0);

    // bltu x1,x2
    push(32'h0020E063, 32'h100, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1);
    check("bltu_alu", {27'd0, out_alu_ctrl}, 32'b10001);
    check("bltu_src2", out_src2, 32'hFFFFFFFF);
    check("bltu_wen", {31'd0, out_rf_wen}, 32'd0);

    // Backpressure: addi x1,x0,5 loads, then addi x2,x0,10 waits
    in_inst = 32'h00500093; rs1_data = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_inst = 32'h00A00113;
    repeat (3) begin
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_src2", out_src2, 32'd5);
      check("bp_rd", {27'd0, out_rd}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_src2", out_src2, 32'd10);
    check("bp_next_rd", {27'd0, out_rd}, 32'd2);

    // Flush together with an accept drops the incoming instruction
    in_inst = 32'h00000FFF; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);

    // Unknown opcode 0x7F with rd=31
    push(32'h00000FFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_wen", {31'd0, out_rf_wen}, 32'd0);
    check("ill_alu", {27'd0, out_alu_ctrl}, 32'd0);

    // Asynchronous reset while holding
    push(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("hold_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_src2", out_src2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized stream against the reference model
    m_valid = 1'b0;
    m_out = resolve('{ill: 1'b1, alu: 5'd0, s1: 0, s2_rs2: 1'b0, imm: 32'd0, is_csr: 1'b0, wen: 1'b0},
                    32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) check_out(m_out);
      make_inst(cur_inst, cur_e);
      in_inst   = cur_inst;
      in_pc     = $urandom & 32'hFFFFFFFC;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      csr_rdata = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      exp_rdy   = !m_valid || out_ready;
      #1;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      @(posedge clk);
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && exp_rdy) begin
        m_valid = 1'b1;
        m_out   = resolve(cur_e, cur_inst, in_pc, rs1_data, rs2_data, csr_rdata);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
